// File: rtl/xvc_jtag_shifter.sv
// xvc_jtag_shifter: JTAG back-end for one XVC "shift:" command.
// Takes TMS/TDI byte pairs, bit-bangs TCK/TMS/TDI with a programmable
// half period and returns the captured TDO bits one byte at a time.
module xvc_jtag_shifter #(
    parameter int CNT_W = 32,
    parameter int HP_W  = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_num_bits,
    input  logic [HP_W-1:0]  cmd_half_period,
    input  logic             word_valid,
    output logic             word_ready,
    input  logic [7:0]       word_tms,
    input  logic [7:0]       word_tdi,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_tdo,
    output logic             done,
    output logic             jtag_tck,
    output logic             jtag_tms,
    output logic             jtag_tdi,
    input  logic             jtag_tdo
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOW,
        S_HIGH,
        S_EMIT,
        S_FIN
    } state_t;

    state_t           state;
    state_t           next_state;

    logic [CNT_W-1:0] remaining;   // bits still to be clocked out
    logic [HP_W-1:0]  half;        // latched half period, never 0
    logic [HP_W-1:0]  hcnt;        // cycles left in the current TCK phase
    logic [7:0]       tms_sr;
    logic [7:0]       tdi_sr;
    logic [7:0]       tdo_sr;
    logic [2:0]       bit_idx;     // bit position within the current byte
    logic [3:0]       bits_left;   // bits left in the current byte
    logic             tck_q;
    logic             tms_q;
    logic             tdi_q;
    logic             done_q;

    logic             phase_end;

    assign phase_end  = (hcnt == '0);

    assign cmd_ready  = (state == S_IDLE);
    assign word_ready = (state == S_FETCH);
    assign out_valid  = (state == S_EMIT);
    assign out_tdo    = tdo_sr;
    assign done       = done_q;
    assign jtag_tck   = tck_q;
    assign jtag_tms   = tms_q;
    assign jtag_tdi   = tdi_q;

    // State register.
    // NOTE: all clocked state uses non-blocking assignments so every
    // register samples pre-edge values regardless of process ordering.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode.
    // NOTE: next_state gets its default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    next_state = (cmd_num_bits == '0) ? S_FIN : S_FETCH;
                end
            end
            S_FETCH: begin
                if (word_valid) begin
                    next_state = S_LOW;
                end
            end
            S_LOW: begin
                if (phase_end) begin
                    next_state = S_HIGH;
                end
            end
            S_HIGH: begin
                if (phase_end) begin
                    next_state = (bits_left == 4'd1) ? S_EMIT : S_LOW;
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    next_state = (remaining == '0) ? S_FIN : S_FETCH;
                end
            end
            S_FIN: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Datapath: command latch, shift registers, phase timer and pin drivers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            remaining <= '0;
            half      <= '0;
            hcnt      <= '0;
            tms_sr    <= '0;
            tdi_sr    <= '0;
            tdo_sr    <= '0;
            bit_idx   <= '0;
            bits_left <= '0;
            tck_q     <= 1'b0;
            tms_q     <= 1'b0;
            tdi_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            // done is registered off FIN so it is a clean one-cycle pulse.
            done_q <= (state == S_FIN);
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        remaining <= cmd_num_bits;
                        half      <= (cmd_half_period == '0) ? HP_W'(1) : cmd_half_period;
                    end
                end
                S_FETCH: begin
                    if (word_valid) begin
                        tms_sr    <= word_tms;
                        tdi_sr    <= word_tdi;
                        tdo_sr    <= '0;
                        bit_idx   <= '0;
                        bits_left <= (remaining >= CNT_W'(8)) ? 4'd8 : remaining[3:0];
                        // Entering LOW: present the first bit of the new byte.
                        tms_q     <= word_tms[0];
                        tdi_q     <= word_tdi[0];
                        hcnt      <= half - HP_W'(1);
                    end
                end
                S_LOW: begin
                    if (phase_end) begin
                        tck_q           <= 1'b1;
                        tdo_sr[bit_idx] <= jtag_tdo;
                        hcnt            <= half - HP_W'(1);
                    end else begin
                        hcnt <= hcnt - HP_W'(1);
                    end
                end
                S_HIGH: begin
                    if (phase_end) begin
                        tck_q     <= 1'b0;
                        tms_sr    <= tms_sr >> 1;
                        tdi_sr    <= tdi_sr >> 1;
                        remaining <= remaining - CNT_W'(1);
                        bit_idx   <= bit_idx + 3'd1;
                        bits_left <= bits_left - 4'd1;
                        hcnt      <= half - HP_W'(1);
                        // Only advance the pins when another LOW follows; at the
                        // end of a byte they hold their last value while stalled.
                        if (bits_left != 4'd1) begin
                            tms_q <= tms_sr[1];
                            tdi_q <= tdi_sr[1];
                        end
                    end else begin
                        hcnt <= hcnt - HP_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xvc_jtag_shifter.sv
// Directed testbench for xvc_jtag_shifter with hand-computed expectations.
module tb_xvc_jtag_shifter;

    localparam int CNT_W = 32;
    localparam int HP_W  = 16;

    logic             clock = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [CNT_W-1:0] cmd_num_bits;
    logic [HP_W-1:0]  cmd_half_period;
    logic             word_valid;
    logic             word_ready;
    logic [7:0]       word_tms;
    logic [7:0]       word_tdi;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_tdo;
    logic             done;
    logic             jtag_tck;
    logic             jtag_tms;
    logic             jtag_tdi;
    logic             jtag_tdo;

    logic             loop_mode;
    logic             tdo_fixed;

    assign jtag_tdo = loop_mode ? jtag_tdi : tdo_fixed;

    xvc_jtag_shifter #(.CNT_W(CNT_W), .HP_W(HP_W)) dut (
        .clock           (clock),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_num_bits    (cmd_num_bits),
        .cmd_half_period (cmd_half_period),
        .word_valid      (word_valid),
        .word_ready      (word_ready),
        .word_tms        (word_tms),
        .word_tdi        (word_tdi),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_tdo         (out_tdo),
        .done            (done),
        .jtag_tck        (jtag_tck),
        .jtag_tms        (jtag_tms),
        .jtag_tdi        (jtag_tdi),
        .jtag_tdo        (jtag_tdo)
    );

    always #5 clock = ~clock;

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Handshake / activity counters sampled on the active edge.
    int cyc      = 0;
    int hs_cyc   = 0;
    int word_cnt = 0;
    int out_cnt  = 0;
    int wr_cnt   = 0;
    int ov_cnt   = 0;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (cmd_valid && cmd_ready) hs_cyc <= cyc;
        if (word_valid && word_ready) word_cnt <= word_cnt + 1;
        if (out_valid && out_ready) out_cnt <= out_cnt + 1;
        if (word_ready) wr_cnt <= wr_cnt + 1;
        if (out_valid) ov_cnt <= ov_cnt + 1;
    end

    // TCK rise log and done pulses sampled on the opposite edge.
    int           rise_cnt = 0;
    int           done_cnt = 0;
    int           done_cyc = 0;
    logic         prev_tck = 1'b0;
    logic [127:0] tdi_log;
    logic [127:0] tms_log;
    int           rise_cyc [128];

    always @(negedge clock) begin
        prev_tck <= jtag_tck;
        if (jtag_tck && !prev_tck && rise_cnt < 128) begin
            tdi_log[rise_cnt]  <= jtag_tdi;
            tms_log[rise_cnt]  <= jtag_tms;
            rise_cyc[rise_cnt] <= cyc;
            rise_cnt           <= rise_cnt + 1;
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    // Runs one full command; stall>0 holds out_ready low that many cycles on byte 0.
    task automatic run_shift(input int n, input int hp, input logic [31:0] tms_w,
                             input logic [31:0] tdi_w, input int stall,
                             output logic [31:0] tdo_w);
        int         nbytes;
        int         t;
        int         d0;
        logic       ok;
        logic [7:0] snap;
        nbytes = (n + 7) / 8;
        tdo_w  = '0;
        d0     = done_cnt;
        @(negedge clock);
        cmd_valid       = 1'b1;
        cmd_num_bits    = CNT_W'(n);
        cmd_half_period = HP_W'(hp);
        t = 0;
        while (!cmd_ready && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (t >= 50) check("cmd_timeout", 32'(t), 32'd0);
        @(negedge clock);
        cmd_valid = 1'b0;
        for (int b = 0; b < nbytes; b++) begin
            word_valid = 1'b1;
            word_tms   = tms_w[8*b +: 8];
            word_tdi   = tdi_w[8*b +: 8];
            t = 0;
            while (!word_ready && t < 50) begin
                @(negedge clock);
                t++;
            end
            if (t >= 50) check("word_timeout", 32'(t), 32'd0);
            @(negedge clock);
            word_valid = 1'b0;
            t = 0;
            while (!out_valid && t < 2000) begin
                @(negedge clock);
                t++;
            end
            if (t >= 2000) check("out_timeout", 32'(t), 32'd0);
            if (b == 0 && stall > 0) begin
                snap = out_tdo;
                ok   = 1'b1;
                repeat (stall) begin
                    @(negedge clock);
                    if (jtag_tck || out_tdo !== snap || word_ready || !out_valid) ok = 1'b0;
                end
                check("stall_hold", 32'(ok), 32'd1);
            end
            tdo_w[8*b +: 8] = out_tdo;
            out_ready = 1'b1;
            @(negedge clock);
            out_ready = 1'b0;
        end
        t = 0;
        while (done_cnt == d0 && t < 20) begin
            @(negedge clock);
            t++;
        end
        if (t >= 20) check("done_timeout", 32'(t), 32'd0);
        repeat (3) @(negedge clock);
    endtask

    initial begin
        logic [31:0] tdo;
        logic [15:0] exp_tdi;
        int          rb;
        int          wb;
        int          ob;
        int          db;
        int          wrb;
        int          ovb;
        int          t;

        reset           = 1'b1;
        cmd_valid       = 1'b0;
        cmd_num_bits    = '0;
        cmd_half_period = '0;
        word_valid      = 1'b0;
        word_tms        = '0;
        word_tdi        = '0;
        out_ready       = 1'b0;
        loop_mode       = 1'b1;
        tdo_fixed       = 1'b0;

        // Reset state.
        repeat (3) @(negedge clock);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_word_ready", 32'(word_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_tck", 32'(jtag_tck), 32'd0);
        check("rst_out_tdo", 32'(out_tdo), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Reset asserted mid-HIGH of a 16-bit shift with TMS/TDI at 1.
        cmd_valid       = 1'b1;
        cmd_num_bits    = 32'd16;
        cmd_half_period = 16'd4;
        @(negedge clock);
        cmd_valid  = 1'b0;
        word_valid = 1'b1;
        word_tms   = 8'hFF;
        word_tdi   = 8'hFF;
        @(negedge clock);
        word_valid = 1'b0;
        t = 0;
        while (!jtag_tck && t < 50) begin
            @(negedge clock);
            t++;
        end
        check("pre_rst_tck", 32'(jtag_tck), 32'd1);
        check("pre_rst_tdi", 32'(jtag_tdi), 32'd1);
        @(negedge clock);
        db = done_cnt;
        #2 reset = 1'b1;
        #1;
        check("mid_rst_tck", 32'(jtag_tck), 32'd0);
        check("mid_rst_tms", 32'(jtag_tms), 32'd0);
        check("mid_rst_tdi", 32'(jtag_tdi), 32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("post_rst_no_done", 32'(done_cnt - db), 32'd0);

        // 8 bits, H=2, TDI=0xA5 looped back.
        loop_mode = 1'b1;
        rb = rise_cnt; wb = word_cnt; ob = out_cnt; db = done_cnt;
        run_shift(8, 2, 32'h0000_0000, 32'h0000_00A5, 0, tdo);
        exp_tdi = 16'h00A5;
        check("a5_tdo", tdo[7:0], 32'hA5);
        check("a5_rises", 32'(rise_cnt - rb), 32'd8);
        check("a5_words", 32'(word_cnt - wb), 32'd1);
        check("a5_outs", 32'(out_cnt - ob), 32'd1);
        check("a5_done", 32'(done_cnt - db), 32'd1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("a5_tdi_bit%0d", i), 32'(tdi_log[rb+i]), 32'(exp_tdi[i]));
            check($sformatf("a5_tms_bit%0d", i), 32'(tms_log[rb+i]), 32'd0);
        end
        for (int i = 1; i < 8; i++) begin
            check($sformatf("a5_period%0d", i), 32'(rise_cyc[rb+i] - rise_cyc[rb+i-1]), 32'd4);
        end

        // 11 bits, H=1, TDO tied high, partial final byte.
        loop_mode = 1'b0;
        tdo_fixed = 1'b1;
        rb = rise_cnt; wb = word_cnt; ob = out_cnt;
        run_shift(11, 1, 32'h0000_07FF, 32'h0000_053C, 0, tdo);
        exp_tdi = 16'h053C;
        check("b11_tdo0", tdo[7:0], 32'hFF);
        check("b11_tdo1", tdo[15:8], 32'h07);
        check("b11_rises", 32'(rise_cnt - rb), 32'd11);
        check("b11_words", 32'(word_cnt - wb), 32'd2);
        check("b11_outs", 32'(out_cnt - ob), 32'd2);
        for (int i = 0; i < 11; i++) begin
            check($sformatf("b11_tdi_bit%0d", i), 32'(tdi_log[rb+i]), 32'(exp_tdi[i]));
            check($sformatf("b11_tms_bit%0d", i), 32'(tms_log[rb+i]), 32'd1);
        end

        // Zero-length command.
        rb = rise_cnt; wrb = wr_cnt; ovb = ov_cnt; db = done_cnt;
        run_shift(0, 3, 32'h0, 32'h0, 0, tdo);
        check("z_done_latency", 32'(done_cyc - hs_cyc), 32'd2);
        check("z_done_count", 32'(done_cnt - db), 32'd1);
        check("z_rises", 32'(rise_cnt - rb), 32'd0);
        check("z_word_ready", 32'(wr_cnt - wrb), 32'd0);
        check("z_out_valid", 32'(ov_cnt - ovb), 32'd0);

        // Half period 0 behaves as 1.
        loop_mode = 1'b1;
        rb = rise_cnt;
        run_shift(4, 0, 32'h0, 32'h0000_000A, 0, tdo);
        check("h0_tdo", tdo[7:0], 32'h0A);
        check("h0_rises", 32'(rise_cnt - rb), 32'd4);
        for (int i = 1; i < 4; i++) begin
            check($sformatf("h0_period%0d", i), 32'(rise_cyc[rb+i] - rise_cyc[rb+i-1]), 32'd2);
        end

        // Output back-pressure for 20 cycles after the first byte.
        rb = rise_cnt; wb = word_cnt; ob = out_cnt;
        run_shift(16, 1, 32'h0, 32'h0000_3412, 20, tdo);
        check("stall_tdo0", tdo[7:0], 32'h12);
        check("stall_tdo1", tdo[15:8], 32'h34);
        check("stall_rises", 32'(rise_cnt - rb), 32'd16);
        check("stall_words", 32'(word_cnt - wb), 32'd2);
        check("stall_outs", 32'(out_cnt - ob), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
